core_memory: RTL and testbench

- Memory-access stage that consumes the registered execute-stage outputs (result, adder address, rd address).
- Issues data-bus requests using a req/gnt/rvalid handshake, aligns store data and byte enables, and sign/zero-extends load data.
- Produces a registered writeback beat.
- Holds the execute stage via stall_o while a memory transaction is outstanding; the execute stage keeps its outputs stable while stalled.

---
 rtl/core_memory.sv | 193 +++++++++++++++++++
 tb/tb_core_memory.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_memory.sv
// Memory-access stage: drives the req/gnt/rvalid data bus, aligns stores, extends loads and
// registers the writeback beat. Define CORE_MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module core_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_LSB   = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     result_i,
  input  logic [DATA_WIDTH:0]       adder_i,
  input  logic [4:0]                rd_addr_i,
  input  logic [4:0]                mem_op_i,
  output logic                      stall_o,
  output logic                      data_req_o,
  output logic [DATA_WIDTH-1:0]     data_addr_o,
  output logic                      data_we_o,
  output logic [DATA_WIDTH/8-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  output logic                      wb_we_o,
  output logic [4:0]                wb_rd_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misaligned_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [NumBytes-1:0] ByteMask = NumBytes'(1);
  localparam logic [NumBytes-1:0] HalfMask = NumBytes'(3);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e state_q, state_d;

  logic                  mem, misalign, mem_go;
  logic                  is_store, is_uns;
  logic [1:0]            size;
  logic [ADDR_LSB-1:0]   off;
  logic                  req, complete;
  logic [NumBytes-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata, shifted, ld_data;
  logic                  unused_carry;

  logic                  wb_we_q, wb_we_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

  assign mem          = valid_i & mem_op_i[4];
  assign is_store     = mem_op_i[3];
  assign is_uns       = mem_op_i[2];
  assign size         = mem_op_i[1:0];
  assign off          = adder_i[ADDR_LSB-1:0];
  assign unused_carry = adder_i[DATA_WIDTH];

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign misalign = mem & (((size == 2'b01) & off[0]) | (size[1] & (off != '0)));

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misalign;
    end
  end

  assign misaligned_o = misaligned_q;
`else
  assign misalign     = 1'b0;
  assign misaligned_o = 1'b0;
`endif

  assign mem_go = mem & ~misalign;

  // Byte enables and replicated store data; size 2'b11 behaves as a word.
  always_comb begin
    be    = '1;
    wdata = result_i;
    unique case (size)
      2'b00: begin
        be    = ByteMask << off;
        wdata = {NumBytes{result_i[7:0]}};
      end
      2'b01: begin
        be    = HalfMask << off;
        wdata = {(NumBytes / 2){result_i[15:0]}};
      end
      default: begin
        be    = '1;
        wdata = result_i;
      end
    endcase
  end

  assign shifted = data_rdata_i >> {off, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (size)
      2'b00:   ld_data = {{(DATA_WIDTH - 8){~is_uns & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = {{(DATA_WIDTH - 16){~is_uns & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Execute-stage inputs are held stable while stalled, so REQ/WAIT reuse them directly.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_go) begin
          req = 1'b1;
          if (data_gnt_i) begin
            if (is_store) begin
              complete = 1'b1;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        req = 1'b1;
        if (data_gnt_i) begin
          if (is_store) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall_o      = mem_go & ~complete;
  assign data_req_o   = req;
  assign data_we_o    = req & is_store;
  assign data_addr_o  = req ? {adder_i[DATA_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}} : '0;
  assign data_be_o    = req ? be : '0;
  assign data_wdata_o = req ? wdata : '0;

  // Loads only complete from WAIT, so complete & ~is_store marks a returning load.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (complete & ~is_store) begin
      if (rd_addr_i != 5'd0) begin
        wb_we_d   = 1'b1;
        wb_rd_d   = rd_addr_i;
        wb_data_d = ld_data;
      end
    end else if (valid_i & ~mem_op_i[4] & (rd_addr_i != 5'd0)) begin
      wb_we_d   = 1'b1;
      wb_rd_d   = rd_addr_i;
      wb_data_d = result_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= StIdle;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we_o      = wb_we_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_core_memory.sv
// Directed and randomized bench for core_memory; acts as the bus slave and checks against
// an operation-level reference model.
module tb_core_memory;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] result_i = '0;
  logic [32:0] adder_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [4:0]  mem_op_i = '0;
  logic        stall_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        wb_we_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference writeback state
  logic        we_m = 1'b0;
  logic [4:0]  rd_m = '0;
  logic [31:0] data_m = '0;

  core_memory dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .valid_i      (valid_i),
    .result_i     (result_i),
    .adder_i      (adder_i),
    .rd_addr_i    (rd_addr_i),
    .mem_op_i     (mem_op_i),
    .stall_o      (stall_o),
    .data_req_o   (data_req_o),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .wb_we_o      (wb_we_o),
    .wb_rd_addr_o (wb_rd_addr_o),
    .wb_data_o    (wb_data_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input logic mis);
    chk("wb_we", {31'd0, wb_we_o}, {31'd0, we_m});
    chk("wb_rd", {27'd0, wb_rd_addr_o}, {27'd0, rd_m});
    chk("wb_data", wb_data_o, data_m);
    chk("misaligned", {31'd0, misaligned_o}, {31'd0, mis});
  endtask

  // Called just after a rising edge; returns just after the edge that retires the op.
  task automatic do_op(input logic v, input logic [4:0] op, input logic [31:0] res,
                       input logic [32:0] addr, input logic [4:0] rd, input int gd,
                       input int rdl, input logic [31:0] rdata);
    bit mem, st, uns, mis;
    int sz, off, last, be_i;
    longint unsigned v64;
    logic [31:0] exp_wd, exp_ld;
    logic [3:0]  exp_be;
    mem = v && op[4];
    st  = op[3];
    uns = op[2];
    sz  = int'(op[1:0]);
    off = int'(addr[1:0]);
    mis = 1'b0;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    mis = mem && ((sz == 1 && (off % 2) == 1) || (sz >= 2 && off != 0));
`endif
    if (sz == 0) begin
      be_i   = (1 << off) % 16;
      exp_wd = {24'd0, res[7:0]} * 32'h0101_0101;
    end else if (sz == 1) begin
      be_i   = (3 << off) % 16;
      exp_wd = {16'd0, res[15:0]} * 32'h0001_0001;
    end else begin
      be_i   = 15;
      exp_wd = res;
    end
    exp_be = be_i[3:0];
    v64 = longint'(rdata) / (longint'(1) << (8 * off));
    if (sz == 0) begin
      exp_ld = 32'(v64 % 256);
      if (!uns && exp_ld >= 128) exp_ld = exp_ld + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      exp_ld = 32'(v64 % 65536);
      if (!uns && exp_ld >= 32768) exp_ld = exp_ld + 32'hFFFF_0000;
    end else begin
      exp_ld = 32'(v64);
    end

    valid_i   = v;
    mem_op_i  = op;
    result_i  = res;
    adder_i   = addr;
    rd_addr_i = rd;

    if (!mem || mis) begin
      @(negedge clk_i);
      chk("stall_idle", {31'd0, stall_o}, 32'd0);
      chk("req_idle", {31'd0, data_req_o}, 32'd0);
      @(posedge clk_i);
      #1;
      if (!mem && v && rd != 0) begin
        we_m   = 1'b1;
        rd_m   = rd;
        data_m = res;
      end else begin
        we_m = 1'b0;
      end
      chk_wb(mis);
    end else begin
      last = st ? gd : gd + rdl;
      for (int c = 0; c <= last; c++) begin
        data_gnt_i    = (c == gd);
        data_rvalid_i = (!st && c == last) || (c < gd && $urandom_range(0, 2) == 0);
        data_rdata_i  = (c == last) ? rdata : $urandom;
        @(negedge clk_i);
        chk("req", {31'd0, data_req_o}, {31'd0, c <= gd});
        chk("stall", {31'd0, stall_o}, {31'd0, c != last});
        if (c <= gd) begin
          chk("addr", data_addr_o, {addr[31:2], 2'b00});
          chk("be", {28'd0, data_be_o}, {28'd0, exp_be});
          chk("we", {31'd0, data_we_o}, {31'd0, st});
          if (st) chk("wdata", data_wdata_o, exp_wd);
        end
        @(posedge clk_i);
        #1;
      end
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (!st && rd != 0) begin
        we_m   = 1'b1;
        rd_m   = rd;
        data_m = exp_ld;
      end else begin
        we_m = 1'b0;
      end
      chk_wb(1'b0);
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [32:0] a;
    // Reset values
    #2;
    chk("rst_wb_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd_addr_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ALU op, store byte zero-wait, signed/unsigned half loads, back-to-back word ops
    do_op(1'b1, 5'b00000, 32'h1234_5678, 33'h0, 5'd5, 0, 0, 32'h0);
    chk("alu_wb_data", wb_data_o, 32'h1234_5678);
    do_op(1'b1, 5'b11000, 32'h0000_00AB, 33'h100_0003, 5'd3, 0, 0, 32'h0);
    do_op(1'b1, 5'b10001, 32'h0, 33'h200_0002, 5'd9, 2, 3, 32'h8001_0000);
    chk("lh_signed", wb_data_o, 32'hFFFF_8001);
    do_op(1'b1, 5'b10101, 32'h0, 33'h200_0002, 5'd9, 2, 3, 32'h8001_0000);
    chk("lh_unsigned", wb_data_o, 32'h0000_8001);
    do_op(1'b1, 5'b10010, 32'h0, 33'h300_0000, 5'd4, 0, 2, 32'hCAFE_F00D);
    do_op(1'b1, 5'b11010, 32'h5555_AAAA, 33'h300_0004, 5'd4, 0, 0, 32'h0);
    do_op(1'b1, 5'b10001, 32'h0, 33'h300_0003, 5'd6, 1, 1, 32'h7F00_0000);
    do_op(1'b1, 5'b10010, 32'h0, 33'h300_0001, 5'd7, 0, 1, 32'h1122_3344);
    do_op(1'b1, 5'b00000, 32'hDEAD_BEEF, 33'h0, 5'd0, 0, 0, 32'h0);

    // Reset while a load is waiting for rvalid; the late rvalid must be dropped
    valid_i   = 1'b1;
    mem_op_i  = 5'b10010;
    adder_i   = 33'h400_0000;
    rd_addr_i = 5'd8;
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("rst_txn_req", {31'd0, data_req_o}, 32'd1);
    @(posedge clk_i);
    #1;
    data_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("wait_stall", {31'd0, stall_o}, 32'd1);
    #1;
    arst_ni = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("midrst_wb_we", {31'd0, wb_we_o}, 32'd0);
    chk("midrst_wb_data", wb_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    arst_ni       = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h9999_9999;
    @(posedge clk_i);
    #1;
    data_rvalid_i = 1'b0;
    we_m   = 1'b0;
    rd_m   = '0;
    data_m = '0;
    chk_wb(1'b0);
    chk("late_rv_stall", {31'd0, stall_o}, 32'd0);
    chk("late_rv_req", {31'd0, data_req_o}, 32'd0);
    do_op(1'b1, 5'b11010, 32'h0BAD_F00D, 33'h400_0008, 5'd1, 0, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom);
      a  = {1'($urandom), 32'($urandom)};
      do_op(1'($urandom_range(0, 5) != 0), op, $urandom, a, 5'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
